// File: rtl/seg_pkg.sv
// Shared constants for the BCD display slice: active-low segment patterns,
// conversion FSM encodings and small nibble helpers.
package seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction applied to each nibble before a shift
    function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD engine: IDLE -> SHIFT (WIDTH cycles) -> DONE.
// bcd is only valid while done is high.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIG  = 3
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*NDIG-1:0]   bcd,
    output logic                done,
    output logic                busy
);

    localparam int unsigned BCD_W = NIB_W * NDIG;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load;
    logic               w_shift;

    // State register; busy/done are registered copies of the next state
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            ST_IDLE:  w_load  = start;
            ST_SHIFT: w_shift = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < NDIG; i++) begin
            w_adj[i*NIB_W +: NIB_W] = add3(r_bcd[i*NIB_W +: NIB_W]);
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= CNT_W'(WIDTH);
        end else if (w_shift) begin
            {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt - CNT_W'(1);
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: rtl/bcd_seven_seg_scan.sv
// Converts VAL to BCD on change and scans the digits onto a common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NDIG     = 3,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [WIDTH-1:0]    VAL,
    input  logic                EN,
    output logic [6:0]          SEG,
    output logic [NDIG-1:0]     AN,
    output logic                BUSY
);

    localparam int unsigned BCD_W = NIB_W * NDIG;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic               r_valid;
    logic [WIDTH-1:0]   r_last_val;
    logic [WIDTH-1:0]   r_cap;
    logic [BCD_W-1:0]   r_digits;
    logic [PRE_W-1:0]   r_presc;
    logic [IDX_W-1:0]   r_idx;
    logic [SEG_W-1:0]   r_seg;
    logic [NDIG-1:0]    r_an;

    logic               w_start;
    logic               w_done;
    logic               w_busy;
    logic [BCD_W-1:0]   w_bcd;
    logic [NIB_W-1:0]   w_cur;
    logic               w_blank;
    logic [NDIG-1:0]    w_lz;
`ifdef LEADING_ZERO_BLANK_EN
    logic               w_run;
`endif

    // The engine only honours start while idle, so changes during a conversion wait
    assign w_start = !r_valid || (VAL != r_last_val);

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_bin2bcd (
        .CLK   (CLK),
        .CLR   (CLR),
        .start (w_start),
        .bin   (VAL),
        .bcd   (w_bcd),
        .done  (w_done),
        .busy  (w_busy)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_valid    <= 1'b0;
            r_last_val <= '0;
            r_cap      <= '0;
            r_digits   <= '0;
        end else begin
            if (w_start && !w_busy) r_cap <= VAL;
            if (w_done) begin
                r_digits   <= w_bcd;
                r_last_val <= r_cap;
                r_valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Current digit select and leading-zero mask
    always_comb begin
        w_lz    = '0;
        w_cur   = '0;
        w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_run = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            w_run   = w_run && (r_digits[i*NIB_W +: NIB_W] == 4'd0);
            w_lz[i] = w_run;
        end
`endif
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur   = r_digits[i*NIB_W +: NIB_W];
                w_blank = w_lz[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else if (!EN || w_blank) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= seg_decode(w_cur);
            r_an  <= ~(NDIG'(1) << r_idx);
        end
    end

    assign SEG  = r_seg;
    assign AN   = r_an;
    assign BUSY = w_busy;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Self-checking bench for bcd_seven_seg_scan (SCAN_DIV=4); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_seven_seg_scan;

    localparam int WIDTH    = 8;
    localparam int NDIG     = 3;
    localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             CLK;
    logic             CLR;
    logic             EN;
    logic [WIDTH-1:0] VAL;
    logic [6:0]       SEG;
    logic [NDIG-1:0]  AN;
    logic             BUSY;

    typedef struct {
        logic [7:0] val;
        int         d2;
        int         d1;
        int         d0;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];
    int   n_tests;
    int   n_fail;
    int   cyc;

    bcd_seven_seg_scan #(
        .WIDTH    (WIDTH),
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .VAL  (VAL),
        .EN   (EN),
        .SEG  (SEG),
        .AN   (AN),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int pat(input int d);
        case (d)
            0: return 'h40;
            1: return 'h79;
            2: return 'h24;
            3: return 'h30;
            4: return 'h19;
            5: return 'h12;
            6: return 'h02;
            7: return 'h78;
            8: return 'h00;
            9: return 'h10;
            default: return 'h7F;
        endcase
    endfunction

    function automatic bit slot_shown(input int k, input int d1, input int d2);
        if (!LZB || k == 0) return 1'b1;
        if (k == 1) return !(d1 == 0 && d2 == 0);
        return d2 != 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic wait_conv(output int rise, output int len);
        rise = -1;
        len  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (BUSY) begin
                rise = i;
                break;
            end
        end
        if (rise < 0) return;
        len = 1;
        while (len < 40) begin
            tick();
            if (!BUSY) break;
            len++;
        end
    endtask

    // Observe a full scan round and compare each slot with the expected digits
    task automatic check_display(input vec_t e);
        int       dg [3];
        int       segs [3];
        bit       seen [3];
        int       slot;
        dg = '{e.d0, e.d1, e.d2};
        for (int k = 0; k < 3; k++) begin
            segs[k] = 'h7F;
            seen[k] = 1'b0;
        end
        for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
            tick();
            if (AN != 3'b111) begin
                check($sformatf("an_onehot v=%0d", e.val), $countones(~AN), 1);
                slot = !AN[0] ? 0 : (!AN[1] ? 1 : 2);
                segs[slot] = int'(SEG);
                seen[slot] = 1'b1;
            end else begin
                check($sformatf("blank_seg v=%0d", e.val), int'(SEG), 'h7F);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (slot_shown(k, dg[1], dg[2]))
                check($sformatf("slot%0d_seg v=%0d", k, e.val), segs[k], pat(dg[k]));
            else
                check($sformatf("slot%0d_an_blank v=%0d", k, e.val), int'(seen[k]), 0);
        end
    endtask

    task automatic run_conv(input string name);
        int   rise;
        int   len;
        vec_t e;
        wait_conv(rise, len);
        check({name, "_busy_rise"}, rise, 1);
        check({name, "_busy_len"}, len, WIDTH + 1);
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            check_display(e);
        end
    endtask

    initial begin
        int   rise;
        int   len;
        int   len2;
        int   obs;
        bit   fin;
        int   c0;
        int   slot;
        logic [2:0] prev_an;
        logic [2:0] ea;
        int   es;
        int   dg4 [3];
        vec_t e;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        vecs[0] = '{8'd8,   0, 0, 8};
        vecs[1] = '{8'd255, 2, 5, 5};
        vecs[2] = '{8'd7,   0, 0, 7};
        vecs[3] = '{8'd100, 1, 0, 0};
        vecs[4] = '{8'd0,   0, 0, 0};
        vecs[5] = '{8'd99,  0, 9, 9};
        vecs[6] = '{8'd42,  0, 4, 2};
        vecs[7] = '{8'd209, 2, 0, 9};

        CLR = 1'b0;
        EN  = 1'b1;
        VAL = '0;
        #1 CLR = 1'b1;
        tick();
        tick();
        check("reset_seg", int'(SEG), 'h7F);
        check("reset_an", int'(AN), 'h7);
        check("reset_busy", int'(BUSY), 0);

        // First idle cycle after reset converts even though VAL is unchanged
        CLR = 1'b0;
        sb_q.push_back('{8'd0, 0, 0, 0});
        run_conv("post_reset");

        for (int i = 0; i < 8; i++) begin
            VAL = vecs[i].val;
            sb_q.push_back(vecs[i]);
            run_conv($sformatf("vec%0d", i));
        end

        // Reset in the middle of a conversion and a scan slot
        VAL = 8'd123;
        sb_q.push_back('{8'd123, 1, 2, 3});
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (BUSY) begin
                rise = i;
                break;
            end
        end
        check("midconv_busy_rise", rise, 1);
        tick();
        tick();
        tick();
        CLR = 1'b1;
        #1;
        check("midreset_seg", int'(SEG), 'h7F);
        check("midreset_an", int'(AN), 'h7);
        check("midreset_busy", int'(BUSY), 0);
        tick();
        tick();
        CLR = 1'b0;
        run_conv("after_midreset");

        // VAL changes during SHIFT: old value converts first, new one follows
        VAL = 8'd3;
        sb_q.push_back('{8'd3, 0, 0, 3});
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (BUSY) begin
                rise = i;
                break;
            end
        end
        check("chg_busy_rise", rise, 1);
        tick();
        VAL = 8'd4;
        sb_q.push_back('{8'd4, 0, 0, 4});
        len = 2;
        while (len < 40) begin
            tick();
            if (!BUSY) break;
            len++;
        end
        check("chg_first_pulse_len", len, WIDTH + 1);
        e    = sb_q.pop_front();
        obs  = 0;
        len2 = 0;
        fin  = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (AN == 3'b110) begin
                obs++;
                check("chg_hold_old", int'(SEG), pat(e.d0));
            end
            if (BUSY) len2++;
            else if (len2 > 0) fin = 1'b1;
        end
        check("chg_second_pulse_len", len2, WIDTH + 1);
        check("chg_old_observed", int'(obs > 0), 1);
        e = sb_q.pop_front();
        check_display(e);

        // EN low blanks outputs while the scan index keeps moving
        dg4     = '{4, 0, 0};
        prev_an = AN;
        c0      = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (AN == 3'b110 && prev_an != 3'b110) begin
                c0 = cyc;
                break;
            end
            prev_an = AN;
        end
        check("scan_sync", int'(c0 >= 0), 1);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("en_off_seg", int'(SEG), 'h7F);
            check("en_off_an", int'(AN), 'h7);
        end
        EN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            slot = ((cyc - c0) / SCAN_DIV) % NDIG;
            ea   = 3'b111;
            es   = 'h7F;
            if (slot_shown(slot, dg4[1], dg4[2])) begin
                ea[slot] = 1'b0;
                es       = pat(dg4[slot]);
            end
            check($sformatf("en_on_an slot%0d", slot), int'(AN), int'(ea));
            check($sformatf("en_on_seg slot%0d", slot), int'(SEG), es);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
